// File: rtl/pet_kbd_pkg.sv
// pet_kbd_pkg: shared definitions for the PET key-injection block.
// Key-code layout: [7]=shift request, [6:4]=matrix column, [3:0]=matrix row.
// Holds the code field helpers, special codes, left-SHIFT position and the
// sequencer state encoding.
package pet_kbd_pkg;

  localparam int unsigned SHIFT_BIT = 7;
  localparam int unsigned COL_MSB   = 6;
  localparam int unsigned COL_LSB   = 4;
  localparam int unsigned ROW_MSB   = 3;
  localparam int unsigned ROW_LSB   = 0;

  localparam logic [7:0] PAUSE_CODE = 8'h7F;
  localparam logic [3:0] LSHIFT_ROW = 4'd8;
  localparam logic [2:0] LSHIFT_COL = 3'd0;
  localparam logic [3:0] NUM_ROWS   = 4'd10;

  // Sequencer states, kept as plain constants for legacy tool compatibility.
  typedef logic [2:0] state_t;
  localparam state_t StIdle     = 3'd0;
  localparam state_t StShiftPre = 3'd1;
  localparam state_t StPress    = 3'd2;
  localparam state_t StGap      = 3'd3;
  localparam state_t StPause    = 3'd4;

  function automatic logic code_shift(input logic [7:0] code);
    return code[SHIFT_BIT];
  endfunction

  function automatic logic [2:0] code_col(input logic [7:0] code);
    return code[COL_MSB:COL_LSB];
  endfunction

  function automatic logic [3:0] code_row(input logic [7:0] code);
    return code[ROW_MSB:ROW_LSB];
  endfunction

endpackage

// File: rtl/pet_kbd_fifo.sv
// pet_kbd_fifo: synchronous key-code FIFO with sticky overflow flag.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   wr_i, wr_data_i   push strobe and data (dropped when full)
//   rd_i              pop strobe (ignored when empty)
//   flush_i           empty the FIFO and clear overflow; wins over wr_i/rd_i
//   rd_data_o         head entry
//   full_o, empty_o   occupancy flags
//   count_o           number of stored entries
//   overflow_o        sticky: a push was dropped because the FIFO was full
module pet_kbd_fifo #(
  parameter int unsigned Depth = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_i,
  input  logic [7:0]               wr_data_i,
  input  logic                     rd_i,
  input  logic                     flush_i,
  output logic [7:0]               rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic                     overflow_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam logic [AW:0] DepthCnt = (AW + 1)'(Depth);

  logic [7:0]    mem_q [Depth];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;
  logic          ovf_q;
  logic          wr_en, rd_en;

  assign full_o     = (count_q == DepthCnt);
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign overflow_o = ovf_q;
  assign rd_data_o  = mem_q[rptr_q];

  assign wr_en = wr_i & ~full_o & ~flush_i;
  assign rd_en = rd_i & ~empty_o & ~flush_i;

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      // Pointers wrap naturally because Depth is a power of two.
      if (wr_en) wptr_q <= wptr_q + 1'b1;
      if (rd_en) rptr_q <= rptr_q + 1'b1;
      unique case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (wr_i && full_o) ovf_q <= 1'b1;
    end
  end

endmodule

// File: rtl/pet_autotype.sv
// pet_autotype: replays queued PET key codes as timed press/release events on
// the keyboard matrix, inserting left SHIFT when requested.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   wr, wr_data  host write of one key code per cycle (8'h7F = pause)
//   flush        abort: empty the queue and release all keys
//   kbd_busy     a physical key is held; new characters wait for it
//   keyrow       matrix row currently scanned
//   inj_keyin    active-low column pattern for keyrow (ANDed with physical keys)
//   full         queue full
//   busy         queue non-empty or a character/pause in progress
//   overflow     sticky: a write was dropped while full
module pet_autotype
  import pet_kbd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned TICK_DIV    = 50000,
  parameter int unsigned SETUP_TICKS = 2,
  parameter int unsigned HOLD_TICKS  = 4,
  parameter int unsigned GAP_TICKS   = 4,
  parameter int unsigned PAUSE_TICKS = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr,
  input  logic [7:0] wr_data,
  input  logic       flush,
  input  logic       kbd_busy,
  input  logic [3:0] keyrow,
  output logic [7:0] inj_keyin,
  output logic       full,
  output logic       busy,
  output logic       overflow
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PrescMax = PW'(TICK_DIV - 1);

  // FIFO
  logic [7:0]                    head;
  logic                          f_empty;
  logic [$clog2(FIFO_DEPTH):0]   f_count;
  logic                          pop;

  pet_kbd_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk),
    .rst_i      (reset),
    .wr_i       (wr),
    .wr_data_i  (wr_data),
    .rd_i       (pop),
    .flush_i    (flush),
    .rd_data_o  (head),
    .full_o     (full),
    .empty_o    (f_empty),
    .count_o    (f_count),
    .overflow_o (overflow)
  );

  // Sequencer state
  state_t        state_q, state_d;
  logic [7:0]    code_q, code_d;
  logic [15:0]   timer_q, timer_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          enter_timed;
  logic          tick;
  logic          timer_done;
  logic [15:0]   timer_dec;

  assign tick       = (presc_q == PrescMax);
  // The final tick ends the state in the same cycle, so N ticks last exactly
  // N prescaler periods; a zero load exits on the next clock.
  assign timer_done = (timer_q == 16'd0) || (tick && (timer_q == 16'd1));
  assign timer_dec  = tick ? (timer_q - 16'd1) : timer_q;

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    timer_d     = timer_q;
    pop         = 1'b0;
    enter_timed = 1'b0;
    if (flush) begin
      state_d     = StGap;
      timer_d     = 16'(GAP_TICKS);
      enter_timed = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!f_empty && !kbd_busy) begin
            pop    = 1'b1;
            code_d = head;
            if (head == PAUSE_CODE) begin
              state_d     = StPause;
              timer_d     = 16'(PAUSE_TICKS);
              enter_timed = 1'b1;
            end else if (code_row(head) >= NUM_ROWS) begin
              // Invalid row: discard and stay idle.
              state_d = StIdle;
            end else if (code_shift(head)) begin
              state_d     = StShiftPre;
              timer_d     = 16'(SETUP_TICKS);
              enter_timed = 1'b1;
            end else begin
              state_d     = StPress;
              timer_d     = 16'(HOLD_TICKS);
              enter_timed = 1'b1;
            end
          end
        end
        StShiftPre: begin
          if (timer_done) begin
            state_d     = StPress;
            timer_d     = 16'(HOLD_TICKS);
            enter_timed = 1'b1;
          end else begin
            timer_d = timer_dec;
          end
        end
        StPress: begin
          if (timer_done) begin
            state_d     = StGap;
            timer_d     = 16'(GAP_TICKS);
            enter_timed = 1'b1;
          end else begin
            timer_d = timer_dec;
          end
        end
        StGap, StPause: begin
          if (timer_done) begin
            state_d = StIdle;
          end else begin
            timer_d = timer_dec;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Free-running prescaler, restarted on entry to any timed state so the
  // entry cycle never coincides with a tick.
  always_comb begin
    if (enter_timed || tick) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      code_q  <= '0;
      timer_q <= '0;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      timer_q <= timer_d;
      presc_q <= presc_d;
    end
  end

  // Matrix decode
  logic key_on, shift_on;

  assign key_on   = (state_q == StPress);
  assign shift_on = (state_q == StShiftPre) || (key_on && code_shift(code_q));

  always_comb begin
    inj_keyin = 8'hFF;
    if (key_on && (keyrow == code_row(code_q))) begin
      inj_keyin[code_col(code_q)] = 1'b0;
    end
    if (shift_on && (keyrow == LSHIFT_ROW)) begin
      inj_keyin[LSHIFT_COL] = 1'b0;
    end
  end

  assign busy = (f_count != '0) || (state_q != StIdle);

endmodule

// File: tb/tb_pet_autotype.sv
module tb_pet_autotype;

  localparam int unsigned TDIV  = 4;
  localparam int          PRE_C = 1 * 4;   // SETUP_TICKS * TICK_DIV cycles
  localparam int          HLD_C = 2 * 4;   // HOLD_TICKS * TICK_DIV cycles

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       flush = 1'b0;
  logic       kbd_busy = 1'b0;
  logic [3:0] keyrow = 4'd0;
  logic [7:0] inj_keyin;
  logic       full, busy, overflow;

  pet_autotype #(
    .FIFO_DEPTH  (16),
    .TICK_DIV    (TDIV),
    .SETUP_TICKS (1),
    .HOLD_TICKS  (2),
    .GAP_TICKS   (2),
    .PAUSE_TICKS (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wr        (wr),
    .wr_data   (wr_data),
    .flush     (flush),
    .kbd_busy  (kbd_busy),
    .keyrow    (keyrow),
    .inj_keyin (inj_keyin),
    .full      (full),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #50 clk = ~clk;

  typedef struct {
    logic [79:0] snap;
    int          dur;   // -1: duration not checked (truncated phase)
  } phase_t;

  typedef struct {
    logic [7:0]  code;
    logic [79:0] pre_snap;
    int          pre_dur;
    logic [79:0] key_snap;
    int          key_dur;
  } vec_t;

  phase_t      exp_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          last_rise = 0;
  int          last_fall = 0;
  logic        mon_en = 1'b0;
  logic [79:0] cur_snap = '0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: scan all rows once per cycle into an 80-bit pressed-key map.
  // Each non-empty run of identical maps is a phase, compared when it ends.
  always begin : monitor
    logic [79:0] snap, prev_snap;
    int          run_len;
    phase_t      e;
    prev_snap = '0;
    run_len   = 0;
    forever begin
      @(negedge clk);
      cyc++;
      for (int r = 0; r < 10; r++) begin
        keyrow = 4'(r);
        #1;
        for (int c = 0; c < 8; c++) snap[r*8+c] = ~inj_keyin[c];
      end
      cur_snap = snap;
      if (mon_en) begin
        if (snap != prev_snap) begin
          if (prev_snap != '0) begin
            if (exp_q.size() == 0) begin
              check("unexpected_press", prev_snap, '0);
            end else begin
              e = exp_q.pop_front();
              check("phase_keys", prev_snap, e.snap);
              if (e.dur >= 0) check_int("phase_len", run_len, e.dur);
            end
          end
          if (prev_snap == '0) last_rise = cyc;
          if (snap == '0) last_fall = cyc;
          run_len = 1;
        end else begin
          run_len++;
        end
        prev_snap = snap;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #20;
    end
  endtask

  task automatic push_phase(input logic [79:0] s, input int d);
    phase_t p;
    p.snap = s;
    p.dur  = d;
    exp_q.push_back(p);
  endtask

  // Reference model of what one accepted code shows on the matrix.
  task automatic push_code(input logic [7:0] c);
    logic [79:0] k;
    if (c == 8'h7F || c[3:0] >= 4'd10) return;
    k = '0;
    k[int'(c[3:0]) * 8 + int'(c[6:4])] = 1'b1;
    if (c[7]) begin
      if (k == (80'd1 << 64)) begin
        push_phase(k, PRE_C + HLD_C);
      end else begin
        push_phase(80'd1 << 64, PRE_C);
        push_phase(k | (80'd1 << 64), HLD_C);
      end
    end else begin
      push_phase(k, HLD_C);
    end
  endtask

  task automatic wr_code(input logic [7:0] c, output int s);
    wr      = 1'b1;
    wr_data = c;
    s       = cyc;
    step(1);
    wr = 1'b0;
  endtask

  task automatic wait_idle(input int bound, output int t);
    logic ok;
    ok = 1'b0;
    t  = cyc;
    for (int i = 0; i < bound && !ok; i++) begin
      if (!busy) begin
        ok = 1'b1;
        t  = cyc;
      end else begin
        step(1);
      end
    end
    check_int("idle_reached", int'(ok), 1);
  endtask

  // 16 plain codes after 'first' with the keyboard busy; the 17th is dropped.
  task automatic fill17(input logic [7:0] first);
    logic [7:0] c;
    int         s;
    for (int i = 0; i < 17; i++) begin
      c = (i == 0) ? first : {1'b0, 3'(i % 8), 4'(i % 10)};
      wr_code(c, s);
      if (i < 16) push_code(c);
    end
  endtask

  vec_t vecs[7];

  initial begin : stim
    int     s, t, fc;
    phase_t keep;

    vecs[0] = '{8'h04, '0,            0, 80'd1 << 32,                   HLD_C};
    vecs[1] = '{8'hE6, 80'd1 << 64, PRE_C, (80'd1 << 54) | (80'd1 << 64), HLD_C};
    vecs[2] = '{8'h37, '0,            0, 80'd1 << 59,                   HLD_C};
    vecs[3] = '{8'h88, '0,            0, 80'd1 << 64,           PRE_C + HLD_C};
    vecs[4] = '{8'h09, '0,            0, 80'd1 << 72,                   HLD_C};
    vecs[5] = '{8'hF9, 80'd1 << 64, PRE_C, (80'd1 << 79) | (80'd1 << 64), HLD_C};
    vecs[6] = '{8'h0C, '0,            0, '0,                                0};

    // Reset state
    step(3);
    reset = 1'b0;
    mon_en = 1'b1;
    check_int("rst_busy", int'(busy), 0);
    check_int("rst_full", int'(full), 0);
    check_int("rst_overflow", int'(overflow), 0);
    step(1);
    check("rst_keys", cur_snap, '0);

    // Single characters, with and without SHIFT, plus an invalid row
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].pre_dur > 0) push_phase(vecs[i].pre_snap, vecs[i].pre_dur);
      if (vecs[i].key_snap != '0) push_phase(vecs[i].key_snap, vecs[i].key_dur);
      wr_code(vecs[i].code, s);
      check_int("busy_after_wr", int'(busy), 1);
      wait_idle(300, t);
      if (vecs[i].key_snap != '0) begin
        check_int("start_latency", last_rise - s, 2);
        check_int("gap_to_idle", t - last_fall, 2 * TDIV);
      end
      check_int("queue_drained", exp_q.size(), 0);
    end

    // Fill while the physical keyboard is busy, then replay in order
    kbd_busy = 1'b1;
    fill17(8'h01);
    check_int("fill_full", int'(full), 1);
    check_int("fill_overflow", int'(overflow), 1);
    step(5);
    check("fill_no_keys", cur_snap, '0);
    check_int("fill_no_pop", exp_q.size(), 16);
    kbd_busy = 1'b0;
    wait_idle(600, t);
    check_int("replay_drained", exp_q.size(), 0);
    check_int("replay_full", int'(full), 0);
    check_int("overflow_sticky", int'(overflow), 1);

    // Pause code delays the next character by 3 ticks
    wr_code(8'h7F, s);
    wr_code(8'h04, t);
    push_code(8'h04);
    wait_idle(300, t);
    check_int("pause_latency", last_rise - s, 15);
    check_int("pause_drained", exp_q.size(), 0);

    // Flush mid-PRESS with 5 queued; simultaneous write is discarded
    for (int i = 0; i < 6; i++) begin
      wr_code(8'h11 + 8'(i), s);
      push_code(8'h11 + 8'(i));
    end
    check("flush_pre_keys", cur_snap, 80'd1 << 9);
    check_int("flush_pre_overflow", int'(overflow), 1);
    flush   = 1'b1;
    wr      = 1'b1;
    wr_data = 8'h23;
    fc      = cyc;
    keep    = exp_q[0];
    keep.dur = -1;
    exp_q.delete();
    exp_q.push_back(keep);
    step(1);
    flush = 1'b0;
    wr    = 1'b0;
    check("flush_keys", cur_snap, '0);
    check_int("flush_busy_gap", int'(busy), 1);
    check_int("flush_overflow", int'(overflow), 0);
    check_int("flush_full", int'(full), 0);
    wait_idle(100, t);
    check_int("flush_gap_len", t - fc, 9);
    step(40);
    check_int("flush_drained", exp_q.size(), 0);

    // Reset during SHIFT_PRE with a full queue and overflow set
    kbd_busy = 1'b1;
    fill17(8'hE6);
    check_int("pre_rst_overflow", int'(overflow), 1);
    kbd_busy = 1'b0;
    step(2);
    check("pre_rst_shift", cur_snap, 80'd1 << 64);
    reset = 1'b1;
    exp_q.delete();
    push_phase(80'd1 << 64, -1);
    step(1);
    reset = 1'b0;
    check("post_rst_keys", cur_snap, '0);
    check_int("post_rst_busy", int'(busy), 0);
    check_int("post_rst_full", int'(full), 0);
    check_int("post_rst_overflow", int'(overflow), 0);
    push_code(8'h04);
    wr_code(8'h04, s);
    wait_idle(300, t);
    check_int("post_rst_latency", last_rise - s, 2);
    check_int("post_rst_drained", exp_q.size(), 0);

    step(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
